// File: rtl/block_fetch_pkg.sv
// Shared definitions for the matrix tile datapath: element/tile geometry
// defaults, fetch FSM state encoding and a counter-width helper.
package block_fetch_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int J_DEF      = 2;
    localparam int K_DEF      = 2;
    localparam int ADDR_W_DEF = 10;

    // Width of the tile origin and matrix dimension inputs.
    localparam int GEO_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Row-major walker over a J x K tile: keeps the i/j counters, the linear
// element index, an incrementally advanced row base address, and flags for
// "element lies inside the matrix" and "this is the last element".
module tile_addr_gen
    import block_fetch_pkg::*;
#(
    parameter  int J      = J_DEF,
    parameter  int K      = K_DEF,
    parameter  int ADDR_W = ADDR_W_DEF,
    localparam int E_W    = cnt_w(J * K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step,
    input  logic [GEO_W-1:0]  start_row,
    input  logic [GEO_W-1:0]  start_col,
    input  logic [GEO_W-1:0]  num_rows,
    input  logic [GEO_W-1:0]  num_cols,
    output logic [ADDR_W-1:0] addr,
    output logic [E_W-1:0]    idx,
    output logic              in_range,
    output logic              last
);

    localparam int I_W = cnt_w(J);
    localparam int J_W = cnt_w(K);
    // One extra bit so origin + offset can never wrap in the bounds test.
    localparam int R_W = GEO_W + 1;

    logic [I_W-1:0]    i_q;
    logic [J_W-1:0]    j_q;
    logic [E_W-1:0]    e_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [GEO_W-1:0]  start_row_q;
    logic [GEO_W-1:0]  start_col_q;
    logic [GEO_W-1:0]  num_rows_q;
    logic [GEO_W-1:0]  num_cols_q;

    // Latch geometry on init, then advance one element per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            i_q         <= '0;
            j_q         <= '0;
            e_q         <= '0;
            row_base_q  <= '0;
            start_row_q <= '0;
            start_col_q <= '0;
            num_rows_q  <= '0;
            num_cols_q  <= '0;
        end else if (init) begin
            i_q         <= '0;
            j_q         <= '0;
            e_q         <= '0;
            // Address arithmetic is modulo 2**ADDR_W, so the product can be
            // formed directly at address width.
            row_base_q  <= ADDR_W'(start_row) * ADDR_W'(num_cols) + ADDR_W'(start_col);
            start_row_q <= start_row;
            start_col_q <= start_col;
            num_rows_q  <= num_rows;
            num_cols_q  <= num_cols;
        end else if (step) begin
            e_q <= e_q + E_W'(1);
            if (j_q == J_W'(K - 1)) begin
                j_q        <= '0;
                i_q        <= i_q + I_W'(1);
                row_base_q <= row_base_q + ADDR_W'(num_cols_q);
            end else begin
                j_q <= j_q + J_W'(1);
            end
        end
    end

    // Address, bounds and last-element decode from the registered walker.
    always_comb begin
        // NOTE: every output gets a value before any condition, so no
        // path through this block can leave a latch behind.
        addr     = row_base_q + ADDR_W'(j_q);
        idx      = e_q;
        in_range = (({1'b0, start_row_q} + R_W'(i_q)) < {1'b0, num_rows_q}) &&
                   (({1'b0, start_col_q} + R_W'(j_q)) < {1'b0, num_cols_q});
        last     = (e_q == E_W'(J * K - 1));
    end

endmodule

// File: rtl/block_fetch.sv
// Tile reader: walks a J x K tile of a row-major matrix held in a
// synchronous-read buffer, zero-fills elements outside the matrix, and
// presents the assembled tile through a valid/ready handshake.
module block_fetch
    import block_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int J      = J_DEF,
    parameter int K      = K_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [GEO_W-1:0]      start_row,
    input  logic [GEO_W-1:0]      start_col,
    input  logic [GEO_W-1:0]      num_rows,
    input  logic [GEO_W-1:0]      num_cols,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic [J*K*DATA_W-1:0] tile,
    output logic                  tile_valid,
    input  logic                  tile_ready
);

    localparam int NE  = J * K;
    localparam int E_W = cnt_w(NE);

    fetch_state_t      state;
    logic              accept;
    logic [ADDR_W-1:0] gen_addr;
    logic [E_W-1:0]    gen_idx;
    logic              gen_in_range;
    logic              gen_last;

    // Element issued last cycle, waiting for its read data.
    logic              cap_valid;
    logic [E_W-1:0]    cap_idx;
    logic              cap_in_range;
    logic [DATA_W-1:0] cap_data;

    assign accept   = (state == IDLE) && start;
    assign cap_data = cap_in_range ? mem_rd_data : '0;

    tile_addr_gen #(
        .J      (J),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init      (accept),
        .step      (state == ISSUE),
        .start_row (start_row),
        .start_col (start_col),
        .num_rows  (num_rows),
        .num_cols  (num_cols),
        .addr      (gen_addr),
        .idx       (gen_idx),
        .in_range  (gen_in_range),
        .last      (gen_last)
    );

    // Control FSM with registered busy and tile_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            tile_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (gen_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state      <= HOLD;
                    tile_valid <= 1'b1;
                end
                HOLD: begin
                    if (tile_valid && tile_ready) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        tile_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    tile_valid <= 1'b0;
                end
            endcase
        end
    end

    // Delay the issued element by one cycle and write its data into the tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the tile is a flop bank rather than a RAM, so it is reset
            // to give the consumer a defined all-zero tile after reset.
            tile         <= '0;
            cap_valid    <= 1'b0;
            cap_idx      <= '0;
            cap_in_range <= 1'b0;
        end else begin
            cap_valid    <= (state == ISSUE);
            cap_idx      <= gen_idx;
            cap_in_range <= gen_in_range;
            if (accept) begin
                tile <= '0;
            end else if (cap_valid) begin
                for (int s = 0; s < NE; s++) begin
                    if (cap_idx == E_W'(s)) begin
                        tile[s*DATA_W +: DATA_W] <= cap_data;
                    end
                end
            end
        end
    end

    // Buffer read port, decoded from registered state; quiet outside ISSUE.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        if (state == ISSUE) begin
            mem_rd_en = gen_in_range;
            mem_addr  = gen_addr;
        end
    end

endmodule

// File: doc/block_fetch.md
# block_fetch

Tile reader for the matrix datapath, the read-side counterpart of the block accumulator. On a start pulse it walks a J×K tile of a row-major matrix held in a synchronous-read buffer, one element per cycle, zero-fills elements outside the matrix bounds, and presents the assembled tile to the block multiplier through a valid/ready handshake. It sits between the matrix buffer and the multiplier operand inputs.

## Interface
- DATA_W, 16, element width in bits; default comes from the shared `DATA_W.
- J, 2, tile rows; default comes from the shared `J.
- K, 2, tile columns; default comes from the shared `K.
- ADDR_W, 10, matrix buffer address width.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle request; accepted only in IDLE.
- start_row, start_col  input  10 each  tile origin; latched on accept.
- num_rows, num_cols  input  10 each  matrix dimensions; latched on accept.
- busy  output  1  high whenever state is not IDLE.
- mem_rd_en  output  1  buffer read strobe.
- mem_addr  output  ADDR_W  buffer read address.
- mem_rd_data  input  DATA_W  read data, valid one cycle after the mem_rd_en edge.
- tile  output  J*K*DATA_W  packed tile; element e=i*K+j occupies bits [e*DATA_W +: DATA_W].
- tile_valid  output  1  tile is complete and stable.
- tile_ready  input  1  consumer accepts the tile.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: on start=1, latch all five geometry inputs, clear element counter e to 0, clear tile to zero, go to ISSUE.
- ISSUE: one element per cycle in row-major order (i outer, j inner). mem_addr = start_row*num_cols + start_col + i*num_cols + j, computed incrementally (row base += num_cols), truncated to ADDR_W.
- In-range test: (start_row+i) < num_rows and (start_col+j) < num_cols, evaluated at 11 bits so there is no wrap. mem_rd_en=1 only for in-range elements; out-of-range elements still take one cycle, and mem_addr is don't-care for them.
- ISSUE goes to DRAIN on the edge where e==J*K-1.
- Capture: the element issued in cycle n is written to tile slot e at the edge ending cycle n+1. The value is mem_rd_data if that element was in range, otherwise 0; this uses a one-cycle delayed copy of e and of the in-range flag.
- DRAIN: captures the last element, then goes to HOLD.
- HOLD: tile_valid=1 and tile is held stable. On tile_valid&&tile_ready, go to IDLE.
- A start pulse outside IDLE is ignored. This includes a start in the same cycle as the HOLD handshake.
- num_rows==0 or num_cols==0: no reads are issued; the tile is all zeros and takes the normal latency.
- Reset: state IDLE, tile all zeros, tile_valid 0, busy 0, counters 0. mem_rd_en and mem_addr are 0 because they are decoded from IDLE. Reset asserted mid-operation abandons the tile immediately.

## Timing
- start sampled at edge T: ISSUE spans cycles T..T+J*K-1, DRAIN is cycle T+J*K, tile_valid rises after edge T+J*K+1.
- Fixed latency: J*K+1 edges from start accept to tile_valid, independent of bounds.
- Throughput: at most one tile per J*K+3 cycles (accept, issue, drain, handshake, return to IDLE).
- mem_rd_en and mem_addr are combinational from registered state and counters; no input-to-output combinational path exists except via mem_rd_data capture.
- tile_valid, tile and busy are registered.

## Structure
- Shared package/header holds: DATA_W, J, K and ADDR_W defaults; the state encoding (IDLE=0, ISSUE=1, DRAIN=2, HOLD=3).
- One sub-module, tile_addr_gen. It contains the i/j counters, the incremental row-base address, the in-range flag and a last-element flag. It is reused later by the accumulator write path.
- Capture register and FSM live in block_fetch.

## Test plan
- 4×4 matrix m[a]=a+1, tile origin (1,2), J=K=2 -> addresses 6,7,10,11 on consecutive cycles; tile={7,8,11,12}; tile_valid rises 5 edges after start.
- Origin (3,3) on 4×4 -> exactly one read, at address 15; tile={16,0,0,0}; latency unchanged.
- Hold tile_ready=0 for 6 cycles after tile_valid -> tile and tile_valid stable throughout; busy=1; returns to IDLE the cycle after ready=1.
- start re-pulsed during ISSUE and during the HOLD handshake -> ignored; exactly one tile is produced and mem_rd_en count is 4.
- rst=0 asserted in the second ISSUE cycle -> tile_valid, busy and mem_rd_en are 0 immediately; a fresh start then yields a correct tile.
- num_cols=0 -> no mem_rd_en pulses; tile all zeros after 5 edges.
